// File: rtl/seq_approx_restoring_divider.sv
// Iterative restoring divider (2*DW / DW), one quotient row per clock, MSB row first.
// Cells in the masked row/column region can be swapped for approximate cells per operation.
module seq_approx_restoring_divider #(
    parameter int unsigned DW          = 8,
    parameter int unsigned APPROX_ROWS = 4,
    parameter int unsigned APPROX_COLS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*DW-1:0]   n,
    input  logic [DW-1:0]     d,
    input  logic              approx_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     q,
    output logic [DW-1:0]     r,
    output logic              dbz,
    output logic              ovf
);

    localparam int unsigned NW = 2 * DW;
    localparam int unsigned KW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   n_lo;
    logic [DW-1:0]   d_l;
    logic            apx_l;
    logic [KW-1:0]   k;

    logic [DW-1:0]   x;
    logic [DW-1:0]   diff;
    logic [DW-1:0]   p_nxt;
    logic            row_apx;
    logic            bor;
    logic            q_bit;

    // One row of the subtractor array; r doubles as the partial remainder P.
    always_comb begin
        x       = {r[DW-2:0], n_lo[k]};
        row_apx = apx_l && (32'(k) < APPROX_ROWS);
        diff    = '0;
        bor     = 1'b0;
        for (int j = 0; j < int'(DW); j++) begin
            if (row_apx && (j < int'(APPROX_COLS))) begin
                diff[j] = 1'b0;
                bor     = x[j] | d_l[j] | ~bor;
            end else begin
                diff[j] = x[j] ^ d_l[j] ^ bor;
                bor     = (~x[j] & d_l[j]) | (~(x[j] ^ d_l[j]) & bor);
            end
        end
        q_bit = r[DW-1] | ~bor;
        p_nxt = q_bit ? diff : x;
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
            n_lo      <= '0;
            d_l       <= '0;
            apx_l     <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        n_lo     <= n[DW-1:0];
                        d_l      <= d;
                        apx_l    <= approx_en;
                        in_ready <= 1'b0;
                        if (d == '0) begin
                            q     <= '1;
                            r     <= n[DW-1:0];
                            dbz   <= 1'b1;
                            ovf   <= 1'b0;
                            state <= DONE;
                        end else begin
                            q     <= '0;
                            r     <= n[NW-1:DW];
                            dbz   <= 1'b0;
                            ovf   <= (n[NW-1:DW] >= d);
                            k     <= KW'(DW - 1);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r <= p_nxt;
                    q <= {q[DW-2:0], q_bit};
                    if (k == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    // Divide-by-zero enters DONE directly, so valid rises one edge later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_approx_restoring_divider.sv
// Randomised self-checking bench for seq_approx_restoring_divider against an arithmetic model.
module tb_seq_approx_restoring_divider;

    localparam int unsigned DW = 8;
    localparam int unsigned AR = 4;
    localparam int unsigned AC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   n;
    logic [7:0]    d;
    logic          approx_en;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    q;
    logic [7:0]    r;
    logic          dbz;
    logic          ovf;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] obs_q, obs_r;
    logic       obs_dbz, obs_ovf;

    seq_approx_restoring_divider #(
        .DW(DW), .APPROX_ROWS(AR), .APPROX_COLS(AC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Long division on integers: exact rows compare the running remainder with d;
    // approximate rows zero the low AC difference bits and propagate x|y|~borrow there.
    function automatic void model(input logic [15:0] nn, input logic [7:0] dd, input bit apx,
                                  output logic [7:0] mq, output logic [7:0] mr,
                                  output bit mdbz, output bit movf);
        int p, rem, xv, m, hi, b, qb;
        mq = '0;
        if (dd == 0) begin
            mq = 8'hFF; mr = nn[7:0]; mdbz = 1'b1; movf = 1'b0;
            return;
        end
        mdbz = 1'b0;
        movf = (nn[15:8] >= dd);
        p = int'(nn[15:8]);
        for (int k = 7; k >= 0; k--) begin
            rem = 2 * p + int'(nn[k]);
            xv  = rem % 256;
            m   = rem / 256;
            if (apx && (k < int'(AR))) begin
                b = 0;
                for (int j = 0; j < int'(AC); j++)
                    b = (((xv >> j) & 1) | ((int'(dd) >> j) & 1) | (1 - b)) & 1;
                hi = (xv >> AC) - (int'(dd) >> AC) - b;
                qb = (m == 1 || hi >= 0) ? 1 : 0;
                p  = qb ? ((hi << AC) & 255) : xv;
            end else begin
                qb = (rem >= int'(dd)) ? 1 : 0;
                p  = qb ? ((rem - int'(dd)) & 255) : xv;
            end
            mq[k] = qb[0];
        end
        mr = 8'(p);
    endfunction

    task automatic run_op(input logic [15:0] nn, input logic [7:0] dd, input bit apx, input int hold);
        logic [7:0] eq, er;
        bit edbz, eovf;
        int cnt;
        model(nn, dd, apx, eq, er, edbz, eovf);
        check("pre_in_ready", 32'(in_ready), 32'd1);
        n = nn; d = dd; approx_en = apx; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 16'(~nn); d = 8'($urandom); approx_en = ~apx;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", 32'(cnt), (dd == 0) ? 32'd1 : 32'd8);
        check("q", 32'(q), 32'(eq));
        check("r", 32'(r), 32'(er));
        check("dbz", 32'(dbz), 32'(edbz));
        check("ovf", 32'(ovf), 32'(eovf));
        obs_q = q; obs_r = r; obs_dbz = dbz; obs_ovf = ovf;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_q", 32'(q), 32'(eq));
            check("hold_r", 32'(r), 32'(er));
            check("hold_flags", {30'd0, dbz, ovf}, {30'd0, edbz, eovf});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; n = '0; d = '0; approx_en = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_qr", {16'd0, q, r}, 32'd0);
        check("rst_flags", {30'd0, dbz, ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Exact division
        run_op(16'd1000, 8'd7, 1'b0, 0);
        check("t1_q", 32'(obs_q), 32'd142);
        check("t1_r", 32'(obs_r), 32'd6);

        // Approximate mask, then the same operands exactly
        run_op(16'h00FF, 8'h01, 1'b1, 0);
        run_op(16'h00FF, 8'h01, 1'b0, 0);
        check("t2_q", 32'(obs_q), 32'hFF);
        check("t2_r", 32'(obs_r), 32'h00);

        // Divide by zero
        run_op(16'h1234, 8'h00, 1'b0, 0);
        check("t3_q", 32'(obs_q), 32'hFF);
        check("t3_r", 32'(obs_r), 32'h34);
        check("t3_dbz", 32'(obs_dbz), 32'd1);

        // Quotient overflow
        run_op(16'h0900, 8'h08, 1'b0, 0);
        check("t4_ovf", 32'(obs_ovf), 32'd1);
        check("t4_dbz", 32'(obs_dbz), 32'd0);

        // Backpressure followed by a second operation
        run_op(16'd1000, 8'd7, 1'b0, 5);
        run_op(16'd50, 8'd5, 1'b0, 0);
        check("t5_q", 32'(obs_q), 32'd10);
        check("t5_r", 32'(obs_r), 32'd0);

        // Reset in the middle of an operation
        n = 16'd1000; d = 8'd7; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_qr", {16'd0, q, r}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_quiet", 32'(out_valid), 32'd0);
        end
        run_op(16'd1000, 8'd7, 1'b0, 0);

        // Random operands, modes and backpressure
        for (int i = 0; i < 300; i++) begin
            logic [15:0] rn;
            logic [7:0]  rd;
            rn = 16'($urandom);
            rd = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) rn[15:8] = 8'($urandom_range(0, 3));
            run_op(rn, rd, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
